// File: rtl/tag_alloc_pkg.sv
// -----------------------------------------------------------------------------
// tag_alloc_pkg
//   Shared definitions for the tag allocator:
//     - search_mode_t : selects the free-slot search order of the zero-finder
//     - tag_w / cnt_w : width helpers for a W-entry pool
//     - mode_of       : maps the integer RR parameter onto search_mode_t
// -----------------------------------------------------------------------------
package tag_alloc_pkg;

    typedef enum logic {
        SEARCH_RR  = 1'b0,  // circular search downward from the last grant
        SEARCH_LOW = 1'b1   // lowest free index first
    } search_mode_t;

    // Bits needed to name one of w tags.
    function automatic int tag_w(input int w);
        return $clog2(w);
    endfunction

    // Bits needed to hold a count from 0 to w inclusive.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic search_mode_t mode_of(input int rr);
        return (rr != 0) ? SEARCH_RR : SEARCH_LOW;
    endfunction

endpackage : tag_alloc_pkg

// File: rtl/tag_alloc_s.sv
// -----------------------------------------------------------------------------
// s : circular zero-finder
//   Finds a zero bit in x_i.
//     any_i = 0 : search circularly downward starting at pos_i-1, so pos_i = 0
//                 starts at W-1 and pos_i itself is the last index examined.
//     any_i = 1 : return the lowest zero bit, ignoring pos_i.
//   Purely combinational.
//
// Ports:
//   x_i      in  W         occupancy vector (1 = taken)
//   pos_i    in  clog2(W)  search reference position
//   any_i    in  1         1 = lowest-zero mode
//   y_o      out W         one-hot of the selected zero (0 when none)
//   y_enc_o  out clog2(W)  index of the selected zero (0 when none)
//   vld_o    out 1         a zero bit exists
// -----------------------------------------------------------------------------
module s
    import tag_alloc_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0]         x_i,
    input  logic [$clog2(W)-1:0] pos_i,
    input  logic                 any_i,
    output logic [W-1:0]         y_o,
    output logic [$clog2(W)-1:0] y_enc_o,
    output logic                 vld_o
);

    localparam int TW = tag_w(W);

    logic          rr_hit;
    logic [TW-1:0] rr_enc;
    logic          lo_hit;
    logic [TW-1:0] lo_enc;
    logic [TW-1:0] idx;

    // Both loops walk from the least-preferred candidate to the most-preferred
    // one, so the last hit written is the winner.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write;
        // otherwise an untaken branch would hold the old value and infer a latch.
        rr_hit = 1'b0;
        rr_enc = '0;
        lo_hit = 1'b0;
        lo_enc = '0;
        idx    = '0;

        // Candidate k is (pos - 1 - k) mod W; W is a power of two, so the
        // TW-bit subtraction wraps correctly (k = W-1 lands on pos itself).
        for (int k = W - 1; k >= 0; k--) begin
            idx = pos_i - TW'(k + 1);
            if (!x_i[idx]) begin
                rr_hit = 1'b1;
                rr_enc = idx;
            end
        end

        for (int i = W - 1; i >= 0; i--) begin
            if (!x_i[i]) begin
                lo_hit = 1'b1;
                lo_enc = TW'(i);
            end
        end
    end

    always_comb begin
        y_enc_o = any_i ? lo_enc : rr_enc;
        vld_o   = any_i ? lo_hit : rr_hit;
        y_o     = vld_o ? (W'(1) << y_enc_o) : '0;
    end

endmodule : s

// File: rtl/tag_alloc.sv
// -----------------------------------------------------------------------------
// tag_alloc : round-robin tag allocator
//   Hands out free slot indices from a pool of W tags over a valid/ready
//   handshake and reclaims them through a single free port. The busy vector and
//   search pointer live here; the s zero-finder picks the next tag from them.
//   Every output is a function of registers only.
//
// Parameters:
//   W   number of tags (power of two, >= 2)
//   RR  1 = round-robin search, 0 = lowest-free-first
//
// Ports:
//   clk          in  1            clock
//   rst          in  1            synchronous active-high reset
//   alloc_vld_o  out 1            a free tag is offered
//   alloc_rdy_i  in  1            requester takes the offered tag
//   alloc_tag_o  out clog2(W)     offered tag
//   free_vld_i   in  1            release a tag
//   free_tag_i   in  clog2(W)     tag being released
//   flush_i      in  1            release all tags
//   busy_o       out W            busy vector
//   count_o      out clog2(W+1)   number of busy tags
//   full_o       out 1            all tags busy
//   empty_o      out 1            no tags busy
//   err_o        out 1            sticky: a free named a non-busy tag
// -----------------------------------------------------------------------------
module tag_alloc
    import tag_alloc_pkg::*;
#(
    parameter int W  = 16,
    parameter int RR = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   alloc_vld_o,
    input  logic                   alloc_rdy_i,
    output logic [$clog2(W)-1:0]   alloc_tag_o,
    input  logic                   free_vld_i,
    input  logic [$clog2(W)-1:0]   free_tag_i,
    input  logic                   flush_i,
    output logic [W-1:0]           busy_o,
    output logic [$clog2(W+1)-1:0] count_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   err_o
);

    localparam int           TW   = tag_w(W);
    localparam int           CW   = cnt_w(W);
    localparam search_mode_t MODE = mode_of(RR);

    logic [W-1:0]  busy_q,  busy_d;
    logic [TW-1:0] ptr_q,   ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q,   err_d;

    logic [W-1:0]  s_onehot;
    logic [TW-1:0] s_enc;
    logic          s_vld;
    logic          accept;
    logic          free_hit;

    s #(
        .W (W)
    ) u_s (
        .x_i     (busy_q),
        .pos_i   (ptr_q),
        .any_i   (MODE == SEARCH_LOW),
        .y_o     (s_onehot),
        .y_enc_o (s_enc),
        .vld_o   (s_vld)
    );

    assign full_o      = (count_q == CW'(W));
    assign empty_o     = (count_q == '0);
    assign alloc_vld_o = !full_o;
    assign alloc_tag_o = s_enc;
    assign busy_o      = busy_q;
    assign count_o     = count_q;
    assign err_o       = err_q;

    assign accept = alloc_vld_o && alloc_rdy_i;
    // The offered tag is never busy, so a free that names it cannot hit and
    // is flagged as an error while the allocation still goes through.
    assign free_hit = free_vld_i && busy_q[free_tag_i];

    always_comb begin
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        err_d   = err_q;

        if (flush_i) begin
            // Flush wipes the pool but keeps a same-cycle grant; the free port
            // is ignored entirely, including its error check.
            busy_d  = '0;
            ptr_d   = '0;
            count_d = '0;
            if (accept) begin
                busy_d  = s_onehot;
                ptr_d   = s_enc;
                count_d = CW'(1);
            end
        end else begin
            if (free_vld_i) begin
                if (free_hit) begin
                    busy_d[free_tag_i] = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end
            if (accept) begin
                busy_d = busy_d | s_onehot;
                ptr_d  = s_enc;
            end
            unique case ({accept, free_hit})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            busy_q  <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // The count register must always agree with the busy vector, and the
    // zero-finder must see a free tag exactly when the pool is not full.
    a_count_matches_busy : assert property (@(posedge clk) disable iff (rst)
        count_q == CW'($countones(busy_q)));

    a_offer_matches_search : assert property (@(posedge clk) disable iff (rst)
        s_vld == alloc_vld_o);

endmodule : tag_alloc

// File: tb/tb_tag_alloc.sv
// -----------------------------------------------------------------------------
// tb_tag_alloc
//   Directed bench for tag_alloc with W = 16. A round-robin instance runs a
//   table of {inputs, expected outputs} vectors; a lowest-first instance and a
//   mid-operation reset are covered by short hand-written sequences.
// -----------------------------------------------------------------------------
module tb_tag_alloc;

    localparam int W = 16;

    typedef struct {
        logic        rdy;
        logic        fvld;
        logic [3:0]  ftag;
        logic        flush;
        logic        exp_vld;
        logic [3:0]  exp_tag;
        logic [15:0] exp_busy;
        logic [4:0]  exp_cnt;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    // Round-robin instance
    logic        r_rdy, r_fvld, r_flush;
    logic [3:0]  r_ftag;
    logic        r_vld, r_full, r_empty, r_err;
    logic [3:0]  r_tag;
    logic [15:0] r_busy;
    logic [4:0]  r_cnt;

    // Lowest-first instance
    logic        l_rdy, l_fvld, l_flush;
    logic [3:0]  l_ftag;
    logic        l_vld, l_full, l_empty, l_err;
    logic [3:0]  l_tag;
    logic [15:0] l_busy;
    logic [4:0]  l_cnt;

    int n_vec = 0;
    int n_bad = 0;

    vec_t vt[34];

    always #5 clk = ~clk;

    tag_alloc #(.W(W), .RR(1)) dut_rr (
        .clk         (clk),
        .rst         (rst),
        .alloc_vld_o (r_vld),
        .alloc_rdy_i (r_rdy),
        .alloc_tag_o (r_tag),
        .free_vld_i  (r_fvld),
        .free_tag_i  (r_ftag),
        .flush_i     (r_flush),
        .busy_o      (r_busy),
        .count_o     (r_cnt),
        .full_o      (r_full),
        .empty_o     (r_empty),
        .err_o       (r_err)
    );

    tag_alloc #(.W(W), .RR(0)) dut_low (
        .clk         (clk),
        .rst         (rst),
        .alloc_vld_o (l_vld),
        .alloc_rdy_i (l_rdy),
        .alloc_tag_o (l_tag),
        .free_vld_i  (l_fvld),
        .free_tag_i  (l_ftag),
        .flush_i     (l_flush),
        .busy_o      (l_busy),
        .count_o     (l_cnt),
        .full_o      (l_full),
        .empty_o     (l_empty),
        .err_o       (l_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rr(input string tag, input logic vld, input logic [3:0] t,
                            input logic [15:0] busy, input logic [4:0] cnt, input logic err);
        check({tag, " vld"},   32'(r_vld),   32'(vld));
        if (vld) check({tag, " tag"}, 32'(r_tag), 32'(t));
        check({tag, " busy"},  32'(r_busy),  32'(busy));
        check({tag, " count"}, 32'(r_cnt),   32'(cnt));
        check({tag, " full"},  32'(r_full),  32'(cnt == 5'd16));
        check({tag, " empty"}, 32'(r_empty), 32'(cnt == 5'd0));
        check({tag, " err"},   32'(r_err),   32'(err));
    endtask

    task automatic check_low(input string tag, input logic [3:0] t,
                             input logic [15:0] busy, input logic [4:0] cnt, input logic err);
        check({tag, " vld"},   32'(l_vld),  32'd1);
        check({tag, " tag"},   32'(l_tag),  32'(t));
        check({tag, " busy"},  32'(l_busy), 32'(busy));
        check({tag, " count"}, 32'(l_cnt),  32'(cnt));
        check({tag, " err"},   32'(l_err),  32'(err));
    endtask

    function automatic vec_t mk(input logic rdy, input logic fvld, input logic [3:0] ftag,
                                input logic flush, input logic vld, input logic [3:0] t,
                                input logic [15:0] busy, input logic [4:0] cnt, input logic err);
        vec_t v;
        v.rdy = rdy; v.fvld = fvld; v.ftag = ftag; v.flush = flush;
        v.exp_vld = vld; v.exp_tag = t; v.exp_busy = busy; v.exp_cnt = cnt; v.exp_err = err;
        return v;
    endfunction

    initial begin
        // Each row: expected outputs before the edge, then inputs for that edge.
        // Rows 0..15: accept every cycle from reset, tags 15 down to 0.
        for (int i = 0; i < 16; i++) begin
            logic [31:0] b32;
            b32   = 32'hFFFF << (16 - i);
            vt[i] = mk(1, 0, 0, 0, 1, 4'(15 - i), b32[15:0], 5'(i), 0);
        end
        vt[16] = mk(1, 1,  7, 0, 0,  0, 16'hFFFF, 16, 0); // full: rdy ignored, free 7
        vt[17] = mk(1, 0,  0, 0, 1,  7, 16'hFF7F, 15, 0); // ptr 0 -> search from 15 finds 7
        vt[18] = mk(0, 1, 15, 0, 0,  0, 16'hFFFF, 16, 0);
        vt[19] = mk(1, 0,  0, 0, 1, 15, 16'h7FFF, 15, 0); // ptr 7: 6..0 busy, wraps to 15
        vt[20] = mk(0, 1, 13, 0, 0,  0, 16'hFFFF, 16, 0);
        vt[21] = mk(1, 0,  0, 0, 1, 13, 16'hDFFF, 15, 0);
        vt[22] = mk(0, 1, 12, 0, 0,  0, 16'hFFFF, 16, 0);
        vt[23] = mk(1, 1, 15, 0, 1, 12, 16'hEFFF, 15, 0); // accept 12 + free busy 15
        vt[24] = mk(0, 0,  0, 1, 1, 15, 16'h7FFF, 15, 0); // count unchanged; flush
        vt[25] = mk(1, 0,  0, 0, 1, 15, 16'h0000,  0, 0);
        vt[26] = mk(1, 0,  0, 0, 1, 14, 16'h8000,  1, 0);
        vt[27] = mk(1, 0,  0, 0, 1, 13, 16'hC000,  2, 0);
        vt[28] = mk(0, 1,  5, 0, 1, 12, 16'hE000,  3, 0); // free of non-busy 5
        vt[29] = mk(1, 0,  0, 0, 1, 12, 16'hE000,  3, 1); // err set, busy/count kept
        vt[30] = mk(1, 0,  0, 0, 1, 11, 16'hF000,  4, 1);
        vt[31] = mk(1, 0,  0, 0, 1, 10, 16'hF800,  5, 1);
        vt[32] = mk(1, 1, 15, 1, 1,  9, 16'hFC00,  6, 1); // flush + accept 9, free ignored
        vt[33] = mk(0, 0,  0, 0, 1,  8, 16'h0200,  1, 1);

        rst = 1'b1;
        r_rdy = 0; r_fvld = 0; r_ftag = 0; r_flush = 0;
        l_rdy = 0; l_fvld = 0; l_ftag = 0; l_flush = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values of both instances
        check_rr("reset_rr", 1, 15, 16'h0000, 0, 0);
        check_low("reset_low", 0, 16'h0000, 0, 0);
        check("reset_low full",  32'(l_full),  32'd0);
        check("reset_low empty", 32'(l_empty), 32'd1);

        // Table-driven round-robin run
        for (int i = 0; i < 34; i++) begin
            check_rr($sformatf("v%0d", i), vt[i].exp_vld, vt[i].exp_tag,
                     vt[i].exp_busy, vt[i].exp_cnt, vt[i].exp_err);
            r_rdy = vt[i].rdy; r_fvld = vt[i].fvld; r_ftag = vt[i].ftag; r_flush = vt[i].flush;
            tick();
            r_rdy = 0; r_fvld = 0; r_ftag = 0; r_flush = 0;
        end

        // Lowest-first: offers 0,1,2; free 1 re-offers 1 only on the next cycle
        l_rdy = 1; tick();
        check_low("low1", 1, 16'h0001, 1, 0);
        tick();
        check_low("low2", 2, 16'h0003, 2, 0);
        tick();
        l_rdy = 0;
        check_low("low3", 3, 16'h0007, 3, 0);
        l_fvld = 1; l_ftag = 1;
        #1;
        check("low free same-cycle tag", 32'(l_tag), 32'd3);
        tick();
        l_fvld = 0;
        check_low("low4", 1, 16'h0005, 2, 0);
        l_rdy = 1; tick();
        check_low("low5", 3, 16'h0007, 3, 0);
        // Free naming the tag being granted: grant wins, error flagged
        l_fvld = 1; l_ftag = 3; tick();
        l_rdy = 0; l_fvld = 0;
        check_low("low6", 4, 16'h000F, 4, 1);

        // Reset mid-operation with traffic present: traffic is discarded
        r_rdy = 1; r_fvld = 1; r_ftag = 9; l_rdy = 1;
        rst = 1'b1;
        tick();
        rst = 1'b0; r_rdy = 0; r_fvld = 0; r_ftag = 0; l_rdy = 0;
        check_rr("rst_mid_rr", 1, 15, 16'h0000, 0, 0);
        check_low("rst_mid_low", 0, 16'h0000, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_tag_alloc
